// File: rtl/mips_datapath.sv
// 8-bit multicycle MIPS-subset datapath: PC, byte-loaded instruction register,
// 8x8 register file, ALU and the md/a/b/aluout holding registers.
module mips_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  memdata,
  input  logic [2:0]  alucontrol,
  input  logic        alusrca,
  input  logic [1:0]  alusrcb,
  input  logic        iord,
  input  logic [3:0]  irwrite,
  input  logic        memtoreg,
  input  logic        pcen,
  input  logic [1:0]  pcsource,
  input  logic        regdst,
  input  logic        regwrite,
  output logic [7:0]  adr,
  output logic [31:0] instr,
  output logic [7:0]  writedata,
  output logic        zero
);

  logic [7:0]  pc, nextpc;
  logic [31:0] instr_q;
  logic [7:0]  md_q, a_q, b_q, aluout_q;
  logic [7:0]  rf_q [8];

  logic [2:0]  ra1, ra2, wa;
  logic [7:0]  rd1, rd2, wd;
  logic [7:0]  srca, srcb, b2, sum, result;

  assign ra1 = instr_q[23:21];
  assign ra2 = instr_q[18:16];
  assign wa  = regdst ? instr_q[13:11] : instr_q[18:16];
  assign wd  = memtoreg ? md_q : aluout_q;

  // Register 0 is hardwired to zero on the read side; writes to it are dropped.
  assign rd1 = (ra1 == 3'd0) ? 8'h00 : rf_q[ra1];
  assign rd2 = (ra2 == 3'd0) ? 8'h00 : rf_q[ra2];

  assign srca = alusrca ? a_q : pc;

  always_comb begin
    srcb = b_q;
    case (alusrcb)
      2'b00: srcb = b_q;
      2'b01: srcb = 8'h01;
      2'b10: srcb = instr_q[7:0];
      2'b11: srcb = {instr_q[5:0], 2'b00};
      default: srcb = b_q;
    endcase
  end

  // alucontrol[2] turns the adder into a subtractor via invert-and-carry-in.
  assign b2  = alucontrol[2] ? ~srcb : srcb;
  assign sum = srca + b2 + {7'b0, alucontrol[2]};

  always_comb begin
    result = 8'h00;
    case (alucontrol[1:0])
      2'b00: result = srca & b2;
      2'b01: result = srca | b2;
      2'b10: result = sum;
      2'b11: result = {7'b0, sum[7]};
      default: result = 8'h00;
    endcase
  end

  assign zero = (result == 8'h00);

  always_comb begin
    nextpc = pc;
    case (pcsource)
      2'b00: nextpc = result;
      2'b01: nextpc = aluout_q;
      2'b10: nextpc = {instr_q[5:0], 2'b00};
      2'b11: nextpc = pc;
      default: nextpc = pc;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= 8'h00;
      instr_q  <= 32'h0;
      md_q     <= 8'h00;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      aluout_q <= 8'h00;
      for (int i = 0; i < 8; i++) rf_q[i] <= 8'h00;
    end else begin
      if (pcen) pc <= nextpc;
      for (int i = 0; i < 4; i++)
        if (irwrite[i]) instr_q[8*i +: 8] <= memdata;
      md_q     <= memdata;
      a_q      <= rd1;
      b_q      <= rd2;
      aluout_q <= result;
      if (regwrite && (wa != 3'd0)) rf_q[wa] <= wd;
    end
  end

  assign adr       = iord ? aluout_q : pc;
  assign instr     = instr_q;
  assign writedata = b_q;

endmodule

// File: tb/tb_mips_datapath.sv
// Directed bench for mips_datapath: drives the control inputs as a controller
// would and observes state through adr, instr, writedata and zero.
module tb_mips_datapath;

  logic        clk;
  logic        reset;
  logic [7:0]  memdata;
  logic [2:0]  alucontrol;
  logic        alusrca;
  logic [1:0]  alusrcb;
  logic        iord;
  logic [3:0]  irwrite;
  logic        memtoreg;
  logic        pcen;
  logic [1:0]  pcsource;
  logic        regdst;
  logic        regwrite;
  logic [7:0]  adr;
  logic [31:0] instr;
  logic [7:0]  writedata;
  logic        zero;

  int vectors = 0;
  int miscompares = 0;

  mips_datapath dut (
    .clk(clk), .reset(reset), .memdata(memdata), .alucontrol(alucontrol),
    .alusrca(alusrca), .alusrcb(alusrcb), .iord(iord), .irwrite(irwrite),
    .memtoreg(memtoreg), .pcen(pcen), .pcsource(pcsource), .regdst(regdst),
    .regwrite(regwrite), .adr(adr), .instr(instr), .writedata(writedata),
    .zero(zero)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    memdata = 8'h00; alucontrol = 3'b000; alusrca = 1'b0; alusrcb = 2'b00;
    iord = 1'b0; irwrite = 4'b0000; memtoreg = 1'b0; pcen = 1'b0;
    pcsource = 2'b00; regdst = 1'b0; regwrite = 1'b0;
  endtask

  // Points instr[18:16] at idx, stages val in md, then writes it via memtoreg.
  task automatic write_reg(input logic [2:0] idx, input logic [7:0] val);
    memdata = {5'b01000, idx}; irwrite = 4'b0100;
    step();
    irwrite = 4'b0000; memdata = val;
    step();
    regwrite = 1'b1; memtoreg = 1'b1; regdst = 1'b0;
    step();
    regwrite = 1'b0; memtoreg = 1'b0;
  endtask

  task automatic sel_regs(input logic [2:0] rs, input logic [2:0] rt);
    memdata = {rs, 2'b00, rt}; irwrite = 4'b0100;
    step();
    irwrite = 4'b0000;
    step();
  endtask

  task automatic test_reset();
    clear_ctrl();
    reset = 1'b0;
    step();
    vectors++;
    if (adr !== 8'h00) begin miscompares++; $display("FAIL reset_adr: got %h expected 00", adr); end
    vectors++;
    if (instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h expected 00000000", instr); end
    vectors++;
    if (writedata !== 8'h00) begin miscompares++; $display("FAIL reset_writedata: got %h expected 00", writedata); end
    vectors++;
    if (zero !== 1'b1) begin miscompares++; $display("FAIL reset_zero: got %b expected 1", zero); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_pc_inc();
    clear_ctrl();
    alusrcb = 2'b01; alucontrol = 3'b010; pcen = 1'b1;
    repeat (3) step();
    pcen = 1'b0;
    #1;
    vectors++;
    if (adr !== 8'h03) begin miscompares++; $display("FAIL pc_inc: got %h expected 03", adr); end
  endtask

  task automatic test_instr_load();
    clear_ctrl();
    memdata = 8'hA5; irwrite = 4'b1111;
    step();
    irwrite = 4'b0000;
    vectors++;
    if (instr !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL instr_all_bytes: got %h expected a5a5a5a5", instr); end
    memdata = 8'h20; irwrite = 4'b0001; step();
    memdata = 8'h08; irwrite = 4'b0010; step();
    memdata = 8'h43; irwrite = 4'b0100; step();
    memdata = 8'h00; irwrite = 4'b1000; step();
    irwrite = 4'b0000;
    vectors++;
    if (instr !== 32'h00430820) begin miscompares++; $display("FAIL instr_bytewise: got %h expected 00430820", instr); end
  endtask

  task automatic test_reg_add();
    clear_ctrl();
    write_reg(3'd2, 8'd5);
    write_reg(3'd3, 8'd7);
    // b sampled r3 on the same edge that wrote it, so it still holds the old value
    vectors++;
    if (writedata !== 8'h00) begin miscompares++; $display("FAIL same_cycle_read: got %h expected 00", writedata); end
    step();
    vectors++;
    if (writedata !== 8'h07) begin miscompares++; $display("FAIL b_after_write: got %h expected 07", writedata); end
    alusrca = 1'b1; alusrcb = 2'b00; alucontrol = 3'b010;
    #1;
    vectors++;
    if (zero !== 1'b0) begin miscompares++; $display("FAIL add_zero: got %b expected 0", zero); end
    step();
    regdst = 1'b1; regwrite = 1'b1;
    step();
    regwrite = 1'b0; regdst = 1'b0; iord = 1'b1;
    #1;
    vectors++;
    if (adr !== 8'd12) begin miscompares++; $display("FAIL add_aluout: got %h expected 0c", adr); end
    iord = 1'b0;
    sel_regs(3'd2, 3'd1);
    vectors++;
    if (writedata !== 8'd12) begin miscompares++; $display("FAIL r1_readback: got %h expected 0c", writedata); end
  endtask

  task automatic test_alu_ops();
    clear_ctrl();
    write_reg(3'd2, 8'd9);
    write_reg(3'd3, 8'd9);
    sel_regs(3'd2, 3'd3);
    alusrca = 1'b1; alucontrol = 3'b110; iord = 1'b1;
    #1;
    vectors++;
    if (zero !== 1'b1) begin miscompares++; $display("FAIL sub_equal_zero: got %b expected 1", zero); end
    step();
    vectors++;
    if (adr !== 8'h00) begin miscompares++; $display("FAIL sub_equal: got %h expected 00", adr); end
    write_reg(3'd4, 8'd3);
    sel_regs(3'd4, 3'd2);
    alucontrol = 3'b111;
    #1;
    vectors++;
    if (zero !== 1'b0) begin miscompares++; $display("FAIL slt_zero: got %b expected 0", zero); end
    step();
    vectors++;
    if (adr !== 8'h01) begin miscompares++; $display("FAIL slt: got %h expected 01", adr); end
    alucontrol = 3'b110; step();
    vectors++;
    if (adr !== 8'hFA) begin miscompares++; $display("FAIL sub_neg: got %h expected fa", adr); end
    alucontrol = 3'b000; step();
    vectors++;
    if (adr !== 8'h01) begin miscompares++; $display("FAIL and: got %h expected 01", adr); end
    alucontrol = 3'b001; step();
    vectors++;
    if (adr !== 8'h0B) begin miscompares++; $display("FAIL or: got %h expected 0b", adr); end
    alucontrol = 3'b100; step();
    vectors++;
    if (adr !== 8'h02) begin miscompares++; $display("FAIL and_not: got %h expected 02", adr); end
  endtask

  task automatic test_imm_and_pc();
    clear_ctrl();
    alucontrol = 3'b010; alusrcb = 2'b10; iord = 1'b1;
    step();
    vectors++;
    if (adr !== 8'h23) begin miscompares++; $display("FAIL imm_byte: got %h expected 23", adr); end
    alusrcb = 2'b11;
    step();
    vectors++;
    if (adr !== 8'h83) begin miscompares++; $display("FAIL imm_shift: got %h expected 83", adr); end
    iord = 1'b0; pcen = 1'b1; pcsource = 2'b01;
    step();
    vectors++;
    if (adr !== 8'h83) begin miscompares++; $display("FAIL pc_from_aluout: got %h expected 83", adr); end
    pcsource = 2'b11;
    step();
    vectors++;
    if (adr !== 8'h83) begin miscompares++; $display("FAIL pc_hold: got %h expected 83", adr); end
    pcsource = 2'b10;
    step();
    pcen = 1'b0;
    vectors++;
    if (adr !== 8'h80) begin miscompares++; $display("FAIL pc_jump: got %h expected 80", adr); end
  endtask

  task automatic test_r0();
    clear_ctrl();
    write_reg(3'd0, 8'hFF);
    sel_regs(3'd0, 3'd0);
    vectors++;
    if (writedata !== 8'h00) begin miscompares++; $display("FAIL r0_read: got %h expected 00", writedata); end
    alusrca = 1'b1; alusrcb = 2'b01; alucontrol = 3'b010; iord = 1'b1;
    step();
    vectors++;
    if (adr !== 8'h01) begin miscompares++; $display("FAIL r0_plus1: got %h expected 01", adr); end
  endtask

  task automatic test_reset_mid();
    clear_ctrl();
    write_reg(3'd3, 8'h5A);
    sel_regs(3'd2, 3'd3);
    vectors++;
    if (writedata !== 8'h5A) begin miscompares++; $display("FAIL pre_reset_b: got %h expected 5a", writedata); end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (adr !== 8'h00) begin miscompares++; $display("FAIL async_reset_adr: got %h expected 00", adr); end
    vectors++;
    if (instr !== 32'h0) begin miscompares++; $display("FAIL async_reset_instr: got %h expected 00000000", instr); end
    vectors++;
    if (writedata !== 8'h00) begin miscompares++; $display("FAIL async_reset_b: got %h expected 00", writedata); end
    step();
    reset = 1'b1;
    sel_regs(3'd2, 3'd3);
    vectors++;
    if (writedata !== 8'h00) begin miscompares++; $display("FAIL rf_cleared: got %h expected 00", writedata); end
  endtask

  // final report
  initial begin
    clear_ctrl();
    reset = 1'b0;
    test_reset();
    test_pc_inc();
    test_instr_load();
    test_reg_add();
    test_alu_ops();
    test_imm_and_pc();
    test_r0();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
